plot_track_pipe: RTL and testbench

Per-pixel pseudo-3D track renderer, successor to the single-line track plotter. Consumes one packed track descriptor per scanline through a valid/ready port into a double-buffered descriptor register, then classifies each pixel as sky, grass, curb, road or lane mark. Classification runs in a 2-stage pipeline to meet pixel_clk timing. Sits between the track generator (per-line descriptor producer) and the VGA colour mux.

---
 rtl/plot_track_pipe.sv | 172 +++++++++++++++++
 tb/tb_plot_track_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_track_pipe.sv
// Per-pixel pseudo-3D track classifier with a double-buffered per-line descriptor.
// Optional lane marking is enabled with `define LANE_MARK_EN.
module plot_track_pipe #(
  parameter int unsigned               X_W        = 10,
  parameter int unsigned               Y_W        = 10,
  parameter int unsigned               COLOR_W    = 4,
  parameter logic [3*COLOR_W-1:0]      SKY_RGB    = 12'h00F,
  parameter logic [3*COLOR_W-1:0]      GRASS_RGB  = 12'h0F0,
  parameter logic [3*COLOR_W-1:0]      ROAD_RGB   = 12'h333,
  parameter logic [3*COLOR_W-1:0]      CURB_A_RGB = 12'hFFF,
  parameter logic [3*COLOR_W-1:0]      CURB_B_RGB = 12'hF00,
  parameter int unsigned               LANE_HW    = 2,
  parameter logic [3*COLOR_W-1:0]      LANE_RGB   = 12'hFF0
) (
  input  logic               pixel_clk,
  input  logic               reset_n,
  input  logic [X_W-1:0]     DrawX,
  input  logic [Y_W-1:0]     DrawY,
  input  logic               line_start,
  input  logic               isTrack,
  input  logic               trk_valid,
  input  logic [3*X_W+1:0]   trk_data,
  output logic               trk_ready,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               pix_valid,
  output logic [Y_W-1:0]     y_out,
  output logic [7:0]         underrun_cnt
);

  localparam int unsigned D_W = 3 * X_W + 2;
  // Three guard bits so mid+hw+clip and mid-hw-clip never wrap.
  localparam int unsigned E_W = X_W + 3;

  typedef enum logic [2:0] {
    SecSky, SecGrassL, SecCurbL, SecRoad, SecCurbR, SecGrassR
  } sec_e;

  logic [D_W-1:0] shadow_q, shadow_d, active_q, active_d;
  logic           shadow_full_q, shadow_full_d;
  logic [7:0]     underrun_q, underrun_d;
  logic           hs;

  assign trk_ready    = reset_n & ~shadow_full_q;
  assign hs           = trk_valid & trk_ready;
  assign underrun_cnt = underrun_q;

  always_comb begin
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    underrun_d    = underrun_q;
    if (line_start) begin
      if (shadow_full_q) begin
        active_d      = shadow_q;
        shadow_full_d = 1'b0;
      end else if (hs) begin
        active_d = trk_data;
      end else if (underrun_q != 8'hFF) begin
        underrun_d = underrun_q + 8'd1;
      end
    end else if (hs) begin
      shadow_d      = trk_data;
      shadow_full_d = 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      underrun_q    <= '0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      underrun_q    <= underrun_d;
    end
  end

  // Classify against active_d so a swap on line_start covers this same pixel.
  logic signed [E_W-1:0] x_s, mid_s, hw_s, clip_s, l0, l1, r1, r0;
  assign x_s    = $signed({3'b000, DrawX});
  assign mid_s  = $signed({3'b000, active_d[3*X_W-1:2*X_W]});
  assign hw_s   = $signed({3'b000, active_d[2*X_W-1:X_W]});
  assign clip_s = $signed({3'b000, active_d[X_W-1:0]});
  assign l0     = mid_s - hw_s - clip_s;
  assign l1     = mid_s - hw_s;
  assign r1     = mid_s + hw_s;
  assign r0     = mid_s + hw_s + clip_s;

  sec_e sec_d, sec_q;

  always_comb begin
    sec_d = SecSky;
    if (isTrack) begin
      if (x_s < l0)      sec_d = SecGrassL;
      else if (x_s < l1) sec_d = SecCurbL;
      else if (x_s < r1) sec_d = SecRoad;
      else if (x_s < r0) sec_d = SecCurbR;
      else               sec_d = SecGrassR;
    end
  end

`ifdef LANE_MARK_EN
  logic signed [E_W-1:0] lane_lo, lane_hi;
  logic                  lane_d, lane_q;
  assign lane_lo = mid_s - $signed(E_W'(LANE_HW));
  assign lane_hi = mid_s + $signed(E_W'(LANE_HW));
  assign lane_d  = active_d[D_W-2] & (x_s >= lane_lo) & (x_s < lane_hi);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) lane_q <= 1'b0;
    else          lane_q <= lane_d;
  end
`else
  logic unused_lane;
  assign unused_lane = ^{LANE_RGB, LANE_HW[0]};
`endif

  logic           stripe_q, vld1_q;
  logic [Y_W-1:0] y1_q;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_q    <= SecSky;
      stripe_q <= 1'b0;
      vld1_q   <= 1'b0;
      y1_q     <= '0;
    end else begin
      sec_q    <= sec_d;
      stripe_q <= active_d[D_W-1];
      vld1_q   <= isTrack;
      y1_q     <= DrawY;
    end
  end

  logic [3*COLOR_W-1:0] rgb_d;

  always_comb begin
    rgb_d = SKY_RGB;
    case (sec_q)
      SecGrassL, SecGrassR: rgb_d = GRASS_RGB;
      SecCurbL, SecCurbR:   rgb_d = stripe_q ? CURB_A_RGB : CURB_B_RGB;
`ifdef LANE_MARK_EN
      SecRoad:              rgb_d = lane_q ? LANE_RGB : ROAD_RGB;
`else
      SecRoad:              rgb_d = ROAD_RGB;
`endif
      default:              rgb_d = SKY_RGB;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      pix_valid <= 1'b0;
      y_out     <= '0;
    end else begin
      red       <= rgb_d[3*COLOR_W-1:2*COLOR_W];
      green     <= rgb_d[2*COLOR_W-1:COLOR_W];
      blue      <= rgb_d[COLOR_W-1:0];
      pix_valid <= vld1_q;
      y_out     <= y1_q;
    end
  end

endmodule

// File: tb/tb_plot_track_pipe.sv
// Scoreboard bench for plot_track_pipe: driver pushes model predictions, monitor pops
// and compares two cycles later.
module tb_plot_track_pipe;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic [9:0]  DrawX     = '0;
  logic [9:0]  DrawY     = '0;
  logic        line_start = 1'b0;
  logic        isTrack   = 1'b0;
  logic        trk_valid = 1'b0;
  logic [31:0] trk_data  = '0;
  logic        trk_ready;
  logic [3:0]  red, green, blue;
  logic        pix_valid;
  logic [9:0]  y_out;
  logic [7:0]  underrun_cnt;

  plot_track_pipe dut (
    .pixel_clk    (pixel_clk),
    .reset_n      (reset_n),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .line_start   (line_start),
    .isTrack      (isTrack),
    .trk_valid    (trk_valid),
    .trk_data     (trk_data),
    .trk_ready    (trk_ready),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .pix_valid    (pix_valid),
    .y_out        (y_out),
    .underrun_cnt (underrun_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        v;
    logic [9:0]  y;
    logic [11:0] rgb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: what the descriptor buffers should hold.
  logic [31:0] m_active = '0;
  logic [31:0] m_shadow = '0;
  bit          m_sf     = 1'b0;
  int          m_und    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit s, input bit dsh, input int m, input int h,
                                     input int c);
    return {s, dsh, m[9:0], h[9:0], c[9:0]};
  endfunction

  function automatic logic [11:0] ref_rgb(input logic [31:0] d, input int x, input bit it);
    int mid, hw, clip;
    logic [11:0] curb;
    mid  = int'(d[29:20]);
    hw   = int'(d[19:10]);
    clip = int'(d[9:0]);
    curb = d[31] ? 12'hFFF : 12'hF00;
    if (!it) return 12'h00F;
    if (x < mid - hw - clip) return 12'h0F0;
    if (x < mid - hw) return curb;
    if (x < mid + hw) begin
`ifdef LANE_MARK_EN
      if (d[30] && x >= mid - 2 && x < mid + 2) return 12'hFF0;
`endif
      return 12'h333;
    end
    if (x < mid + hw + clip) return curb;
    return 12'h0F0;
  endfunction

  task automatic drive(input bit ls, input int x, input bit it, input bit v,
                       input logic [31:0] d);
    exp_t e;
    bit   hs;
    @(negedge pixel_clk);
    chk("trk_ready", {31'b0, trk_ready}, {31'b0, !m_sf});
    chk("underrun_cnt", {24'b0, underrun_cnt}, m_und);
    line_start = ls;
    DrawX      = x[9:0];
    DrawY      = 10'($urandom);
    isTrack    = it;
    trk_valid  = v;
    trk_data   = d;
    hs = v && !m_sf;
    if (ls) begin
      if (m_sf) begin
        m_active = m_shadow;
        m_sf     = 1'b0;
      end else if (hs) begin
        m_active = d;
      end else if (m_und < 255) begin
        m_und++;
      end
    end else if (hs) begin
      m_shadow = d;
      m_sf     = 1'b1;
    end
    e.due = cyc + 2;
    e.v   = it;
    e.y   = DrawY;
    e.rgb = ref_rgb(m_active, x, it);
    q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    @(negedge pixel_clk);
    #1;
    reset_n    = 1'b0;
    trk_valid  = 1'b1;
    trk_data   = $urandom;
    line_start = 1'b0;
    q.delete();
    m_active = '0;
    m_shadow = '0;
    m_sf     = 1'b0;
    m_und    = 0;
    repeat (n) begin
      @(negedge pixel_clk);
      chk("rst_ready", {31'b0, trk_ready}, 32'd0);
      chk("rst_outputs", {9'b0, red, green, blue, pix_valid, y_out}, 32'd0);
      chk("rst_underrun", {24'b0, underrun_cnt}, 32'd0);
    end
    reset_n   = 1'b1;
    trk_valid = 1'b0;
  endtask

  always @(negedge pixel_clk) begin
    exp_t e;
    if (reset_n) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("pixel", {9'b0, pix_valid, y_out, red, green, blue}, {9'b0, e.v, e.y, e.rgb});
      end
    end
  end

  task automatic rand_run(input int n);
    logic [31:0] d;
    int          x;
    for (int i = 0; i < n; i++) begin
      d = ($urandom_range(0, 3) == 0) ? $urandom
        : mk($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1023),
             $urandom_range(0, 300), $urandom_range(0, 100));
      x = ($urandom_range(0, 3) == 0) ? (int'(m_active[29:20]) + $urandom_range(0, 6) - 3)
                                      : $urandom_range(0, 1023);
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      drive($urandom_range(0, 15) == 0, x, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, d);
    end
  endtask

  initial begin
    int gx[];
    logic [31:0] d1, d2, d3, dl;
    d1 = mk(1, 0, 320, 100, 20);
    d2 = mk(0, 0, 50, 100, 20);
    d3 = mk(1, 0, 620, 10, 30);

    do_reset(3);

    // Geometry sweep, descriptor bypassed straight into active.
    drive(1, 100, 1, 1, d1);
    gx = '{199, 200, 219, 220, 419, 420, 439, 440, 0, 1023};
    foreach (gx[i]) drive(0, gx[i], 1, 0, '0);
    drive(0, 300, 0, 0, '0);

    // Left edges below zero, then right edge past the screen.
    drive(0, 5, 1, 1, d2);
    drive(1, 0, 1, 0, '0);
    gx = '{0, 149, 150, 169, 170};
    foreach (gx[i]) drive(0, gx[i], 1, 0, '0);
    drive(1, 639, 1, 1, d3);
    gx = '{629, 630, 639, 659, 660, 1023};
    foreach (gx[i]) drive(0, gx[i], 1, 0, '0);

    // Double buffer: D2 arrives mid-line, D3 offered while shadow full.
    drive(1, 0, 1, 1, d1);
    drive(0, 210, 1, 1, d2);
    drive(0, 220, 1, 1, d3);
    drive(0, 200, 1, 1, d3);
    drive(0, 430, 1, 0, '0);
    drive(1, 60, 1, 0, '0);
    drive(0, 160, 1, 0, '0);

    // Underruns, bypass keeps count, then saturation.
    for (int i = 0; i < 3; i++) drive(1, 160, 1, 0, '0);
    drive(1, 320, 1, 1, d1);
    drive(0, 200, 1, 0, '0);
    for (int i = 0; i < 260; i++) drive(1, $urandom_range(0, 1023), 1, 0, '0);
    drive(0, 420, 1, 0, '0);

    // Lane window around mid, dash on then off.
    dl = mk(1, 1, 320, 100, 20);
    drive(1, 320, 1, 1, dl);
    for (int x = 316; x <= 323; x++) drive(0, x, 1, 0, '0);
    dl = mk(1, 0, 320, 100, 20);
    drive(1, 320, 1, 1, dl);
    for (int x = 316; x <= 323; x++) drive(0, x, 1, 0, '0);

    rand_run(2500);

    // Mid-line reset: active returns to zero until a new descriptor lands.
    do_reset(2);
    gx = '{0, 320, 1023};
    foreach (gx[i]) drive(0, gx[i], 1, 0, '0);
    drive(1, 200, 1, 1, d1);
    drive(0, 440, 1, 0, '0);

    rand_run(800);

    repeat (4) @(negedge pixel_clk);
    chk("drain", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
